// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - multi-cycle segmented adder/subtractor with saturation and carry flags
// Operands are latched whole and summed SEG bits per clock, low segment first.
module addsub_seg #(
   parameter int WIDTH = 17,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a_in,
   input  logic [WIDTH-1:0] op_b_in,
   input  logic             op,
   input  logic             cin,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [2:0]       cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSEG = (WIDTH + SEG - 1) / SEG;
   localparam int PW   = NSEG * SEG;
   localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic             c_q, sat_q, ovf_q, zero_q, in_ready_q, out_valid_q;
   logic [2:0]       cw_q, cout_q;

   logic [PW-1:0]    a_pad, b_pad, acc_d;
   logic [SEG-1:0]   sa, sb, ss;
   logic [SEG:0]     ch;
   logic [2:0]       cw_d;
   logic [WIDTH-1:0] res_d;
   logic             ovf_d;
   logic             unused_pad;

   always_comb begin
      a_pad = PW'(a_q);
      b_pad = PW'(b_q);
      sa    = '0;
      sb    = '0;
      for (int g = 0; g < NSEG; g++) begin
         if (idx_q == IW'(g)) begin
            sa = a_pad[g*SEG +: SEG];
            sb = b_pad[g*SEG +: SEG];
         end
      end
      ch    = '0;
      ss    = '0;
      ch[0] = c_q;
      for (int j = 0; j < SEG; j++) begin
         ss[j]   = sa[j] ^ sb[j] ^ ch[j];
         ch[j+1] = (sa[j] & sb[j]) | (ch[j] & (sa[j] ^ sb[j]));
      end
      // ch[j] is the carry into global bit g*SEG+j; grab the three top carries where they occur
      acc_d = PW'(acc_q);
      cw_d  = cw_q;
      for (int g = 0; g < NSEG; g++) begin
         if (idx_q == IW'(g)) begin
            acc_d[g*SEG +: SEG] = ss;
            for (int j = 1; j <= SEG; j++) begin
               for (int k = 0; k < 3; k++) begin
                  if (g*SEG + j == WIDTH - 2 + k) cw_d[k] = ch[j];
               end
            end
         end
      end
      ovf_d = cw_d[2] ^ cw_d[1];
      res_d = acc_d[WIDTH-1:0];
      if (sat_q && ovf_d)
         res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   assign unused_pad = ^acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         c_q         <= 1'b0;
         sat_q       <= 1'b0;
         cw_q        <= '0;
         sum_q       <= '0;
         cout_q      <= '0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q        <= op_a_in;
               b_q        <= op ? ~op_b_in : op_b_in;
               c_q        <= op ? ~cin : cin;
               sat_q      <= sat;
               idx_q      <= '0;
               acc_q      <= '0;
               cw_q       <= '0;
               in_ready_q <= 1'b0;
               state_q    <= BUSY;
            end
            BUSY: begin
               acc_q <= acc_d[WIDTH-1:0];
               cw_q  <= cw_d;
               c_q   <= ch[SEG];
               if (idx_q == LAST) begin
                  sum_q       <= res_d;
                  cout_q      <= cw_d;
                  ovf_q       <= ovf_d;
                  zero_q      <= (res_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
